// File: rtl/grid_display.sv
// grid_display: pixel colour generator for a ROWS x COLS grid of coloured cells.
//
// Layout uses pixel geometry measured from BORDER_X/BORDER_Y. Each cell spans
// CELL_W pixels, and GAP_W-pixel gaps sit around and between the cells. Every
// range is exclusive-lower and inclusive-upper. Pixels inside the grid extent
// that are not in a cell use GAP_C. All other pixels use the border colour.
// While error is high, the border colour blinks between ERROR_C and BORDER_C
// with a half-period of BLINK_FRAMES frames.
//
// The cell colours are copied into a snapshot on each frameTick. Output is
// drawn only from that snapshot, so the image does not tear mid-frame.
// The design is a two-stage pipeline: stage 1 classifies the pixel, and
// stage 2 registers rgb.
//
// Optional feature: when GRID_DISPLAY_CURSOR_EN is defined, the design draws
// an IND_C row indicator to the left of the grid, beside row cursorRow.
//
// Ports:
//   clk        pixel clock, rising edge
//   reset      asynchronous active-high reset
//   x, y       current pixel coordinate (10 bits each)
//   videoOn    active-video flag
//   frameTick  one-clk pulse per frame
//   cells      packed cell colours, cell (r,c) at [(r*COLS+c)*12 +: 12]
//   cursorRow  indicator row (ignored unless GRID_DISPLAY_CURSOR_EN)
//   error      error level, makes the border blink
//   rgb        registered 12-bit pixel colour
module grid_display #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned CELL_W       = 100,
  parameter int unsigned GAP_W        = 4,
  parameter int unsigned BORDER_X     = 110,
  parameter int unsigned BORDER_Y     = 30,
  parameter int unsigned IND_L        = 11,
  parameter int unsigned IND_OFF      = 6,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] BORDER_C     = 12'h606,
  parameter logic [11:0] ERROR_C      = 12'hA30,
  parameter logic [11:0] GAP_C        = 12'h7FF,
  parameter logic [11:0] IND_C        = 12'hB70
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [9:0]                            x,
  input  logic [9:0]                            y,
  input  logic                                  videoOn,
  input  logic                                  frameTick,
  input  logic [ROWS*COLS*12-1:0]               cells,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cursorRow,
  input  logic                                  error,
  output logic [11:0]                           rgb
);

  localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned GRID_XHI = BORDER_X + (COLS + 1) * GAP_W + COLS * CELL_W;
  localparam int unsigned GRID_YHI = BORDER_Y + (ROWS + 1) * GAP_W + ROWS * CELL_W;

  typedef enum logic [1:0] {
    CLS_BORDER = 2'd0,
    CLS_GAP    = 2'd1,
    CLS_CELL   = 2'd2,
    CLS_IND    = 2'd3
  } cls_t;

  // Pixel classification (stage 1 combinational)
  logic [31:0]    xi, yi;
  logic           in_col, in_row, in_grid, in_ind;
  logic [CIW-1:0] col_idx;
  logic [RIW-1:0] row_idx;
  cls_t           cls_d;

  assign xi = 32'(x);
  assign yi = 32'(y);

  always_comb begin
    in_col  = 1'b0;
    col_idx = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (xi >  BORDER_X + (c + 1) * GAP_W + c * CELL_W &&
          xi <= BORDER_X + (c + 1) * (GAP_W + CELL_W)) begin
        in_col  = 1'b1;
        col_idx = CIW'(c);
      end
    end
  end

  always_comb begin
    in_row  = 1'b0;
    row_idx = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (yi >  BORDER_Y + (r + 1) * GAP_W + r * CELL_W &&
          yi <= BORDER_Y + (r + 1) * (GAP_W + CELL_W)) begin
        in_row  = 1'b1;
        row_idx = RIW'(r);
      end
    end
  end

  assign in_grid = (xi > BORDER_X) && (xi <= GRID_XHI) &&
                   (yi > BORDER_Y) && (yi <= GRID_YHI);

`ifdef GRID_DISPLAY_CURSOR_EN
  // The indicator strip covers only the cell span of the selected row.
  // It does not cover the gaps above or below that row.
  assign in_ind = (xi >  BORDER_X - IND_L - IND_OFF) &&
                  (xi <= BORDER_X - IND_OFF) &&
                  in_row && (32'(cursorRow) < ROWS) && (row_idx == cursorRow);
`else
  logic unused_cursor;
  assign unused_cursor = ^cursorRow;
  assign in_ind        = 1'b0;
`endif

  always_comb begin
    cls_d = CLS_BORDER;
    if (in_row && in_col) cls_d = CLS_CELL;
    else if (in_grid)     cls_d = CLS_GAP;
    else if (in_ind)      cls_d = CLS_IND;
  end

  // Stage 1 registers
  cls_t           cls_s1;
  logic [RIW-1:0] row_s1;
  logic [CIW-1:0] col_s1;
  logic           vid_s1;
  logic           err_s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_s1 <= CLS_BORDER;
      row_s1 <= '0;
      col_s1 <= '0;
      vid_s1 <= 1'b0;
      err_s1 <= 1'b0;
    end else begin
      cls_s1 <= cls_d;
      row_s1 <= row_idx;
      col_s1 <= col_idx;
      vid_s1 <= videoOn;
      err_s1 <= error;
    end
  end

  // Frame snapshot of cell colours
  logic [ROWS*COLS*12-1:0] snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          snap <= '0;
    else if (frameTick) snap <= cells;
  end

  // Blink counter. When error is low, the clear takes priority over a
  // coincident frameTick.
  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!error) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frameTick) begin
      if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Stage 2: colour selection
  logic [11:0] cell_c, border_c;

  always_comb begin
    cell_c   = snap[(32'(row_s1) * COLS + 32'(col_s1)) * 12 +: 12];
    border_c = (err_s1 && !blink_phase) ? ERROR_C : BORDER_C;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= '0;
    end else if (!vid_s1) begin
      rgb <= '0;
    end else begin
      case (cls_s1)
        CLS_CELL: rgb <= cell_c;
        CLS_GAP:  rgb <= GAP_C;
        CLS_IND:  rgb <= IND_C;
        default:  rgb <= border_c;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_display.sv
// Directed bench for grid_display with default parameters. Expected colours
// are pushed to a scoreboard queue when a pixel is driven. They are popped and
// compared once the two-stage latency has elapsed.
module tb_grid_display;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [9:0]              x, y;
  logic                    videoOn, frameTick, error;
  logic [ROWS*COLS*12-1:0] cells;
  logic [1:0]              cursorRow;
  logic [11:0]             rgb;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  grid_display #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .videoOn   (videoOn),
    .frameTick (frameTick),
    .cells     (cells),
    .cursorRow (cursorRow),
    .error     (error),
    .rgb       (rgb)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: rgb=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a pixel one time unit after an edge. The result is on rgb after
  // the second following edge.
  task automatic pixel(input int px, input int py, input logic von,
                       input logic [11:0] exp, input string tag);
    logic [11:0] e;
    string       t;
    x = 10'(px);
    y = 10'(py);
    videoOn = von;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, rgb, e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frameTick = 1'b1;
      @(posedge clk);
      #1 frameTick = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    x = '0; y = '0; videoOn = 1'b0; frameTick = 1'b0; error = 1'b0;
    cells = '0; cursorRow = 2'd0;
    #3;
    cmp("reset_rgb", rgb, 12'h000);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Cell, gap and border colours
    cells[0 +: 12] = 12'hF00;
    ticks(1);
    pixel(150, 50, 1'b1, 12'hF00, "cell00");
    pixel(112, 50, 1'b1, 12'h7FF, "gap");
    pixel(600, 50, 1'b1, 12'h606, "border");
    pixel(214, 50, 1'b1, 12'hF00, "cell00_xhi");
    pixel(215, 50, 1'b1, 12'h7FF, "gap_after_col0");
    pixel(114, 50, 1'b1, 12'h7FF, "gap_before_col0");
    pixel(530, 50, 1'b1, 12'h7FF, "grid_xhi");
    pixel(531, 50, 1'b1, 12'h606, "beyond_grid");

    // The snapshot updates only on frameTick
    cells[15*12 +: 12] = 12'h0F0;
    ticks(1);
    pixel(500, 400, 1'b1, 12'h0F0, "cell33");
    cells[15*12 +: 12] = 12'h00F;
    pixel(500, 400, 1'b1, 12'h0F0, "cell33_no_tick");
    ticks(1);
    pixel(500, 400, 1'b1, 12'h00F, "cell33_after_tick");

    // Error blink
    error = 1'b1;
    pixel(5, 5, 1'b1, 12'hA30, "blink_start");
    ticks(29);
    pixel(5, 5, 1'b1, 12'hA30, "blink_29");
    ticks(1);
    pixel(5, 5, 1'b1, 12'h606, "blink_30");
    ticks(29);
    pixel(5, 5, 1'b1, 12'h606, "blink_59");
    ticks(1);
    pixel(5, 5, 1'b1, 12'hA30, "blink_60");
    error = 1'b0;
    pixel(5, 5, 1'b1, 12'h606, "error_drop");
    error = 1'b1;
    pixel(5, 5, 1'b1, 12'hA30, "error_rise");

    // If error falls on the same edge as a wrapping frameTick, the clear wins
    ticks(29);
    error = 1'b0;
    frameTick = 1'b1;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    error = 1'b1;
    pixel(5, 5, 1'b1, 12'hA30, "clear_wins");
    error = 1'b0;

    // Row indicator
    cursorRow = 2'd1;
`ifdef GRID_DISPLAY_CURSOR_EN
    pixel(100, 200, 1'b1, 12'hB70, "ind_row1");
`else
    pixel(100, 200, 1'b1, 12'h606, "ind_disabled");
`endif
    cursorRow = 2'd0;
    pixel(100, 200, 1'b1, 12'h606, "ind_other_row");

    // Blanking
    pixel(150, 50, 1'b0, 12'h000, "video_off");

    // Asynchronous reset in the middle of a stream
    pixel(150, 50, 1'b1, 12'hF00, "pre_reset");
    #2 reset = 1'b1;
    #1;
    cmp("async_reset", rgb, 12'h000);
    @(posedge clk);
    #1 reset = 1'b0;
    pixel(150, 50, 1'b1, 12'h000, "snap_cleared");
    ticks(1);
    pixel(150, 50, 1'b1, 12'hF00, "snap_reloaded");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
